// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with frame debounce and single-key press/release events.
// Optional KEY_REPEAT_EN adds auto-repeat of key_valid while a key stays held.
//   state   | meaning
//   IDLE    | no key accepted, waiting for a single stable key
//   PRESSED | one key accepted and still held
//   BLOCKED | multi-key or key change seen, waiting for all keys released
module keypad_scanner #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 125
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_release,
  output logic       key_held,
  output logic       multi_key
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_SAMPLE = SLOT_W'(SCAN_DIV - 2);
  localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(SCAN_DIV - 1);
  localparam logic [3:0] DEB = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, PRESSED, BLOCKED} state_t;

  logic [3:0]        row_s1, row_s2;
  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        col_idx;
  logic [15:0]       frame_acc, prev_frame, stable_frame;
  logic [3:0]        match_cnt, match_next;
  logic              stable_upd, frame_tick;
  logic              is_none, is_one, is_multi;
  logic [3:0]        stable_code;
  state_t            state;

  always_comb begin
    if (frame_acc != prev_frame) match_next = 4'd1;
    else if (match_cnt >= DEB)   match_next = DEB;
    else                         match_next = match_cnt + 4'd1;
  end

  // Frame bit index is col*4+row; key code is row*4+col.
  always_comb begin
    stable_code = '0;
    for (int b = 0; b < 16; b++)
      if (stable_frame[b]) stable_code = {2'(b % 4), 2'(b / 4)};
  end

  assign is_none  = (stable_frame == '0);
  assign is_one   = !is_none && ((stable_frame & (stable_frame - 16'd1)) == '0);
  assign is_multi = !is_none && !is_one;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1       <= 4'hF;
      row_s2       <= 4'hF;
      slot_cnt     <= '0;
      col_idx      <= '0;
      col_n        <= 4'b1110;
      frame_acc    <= '0;
      prev_frame   <= '0;
      stable_frame <= '0;
      match_cnt    <= '0;
      stable_upd   <= 1'b0;
      frame_tick   <= 1'b0;
    end else begin
      row_s1     <= row_n;
      row_s2     <= row_s1;
      stable_upd <= 1'b0;
      frame_tick <= 1'b0;
      // Sampling one slot before the column switch gives the strobe time to settle.
      if (slot_cnt == SLOT_SAMPLE)
        frame_acc[{col_idx, 2'b00} +: 4] <= ~row_s2;
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt <= '0;
        col_idx  <= col_idx + 2'd1;
        col_n    <= {col_n[2:0], col_n[3]};
        if (col_idx == 2'd3) begin
          prev_frame <= frame_acc;
          match_cnt  <= match_next;
          frame_tick <= 1'b1;
          if (match_next == DEB && frame_acc != stable_frame) begin
            stable_frame <= frame_acc;
            stable_upd   <= 1'b1;
          end
        end
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_FRAMES + 1);
  logic [RPT_W-1:0] rpt_cnt;
`else
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_FRAMES;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 1'b0;
      multi_key   <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_cnt     <= '0;
`endif
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        IDLE: begin
          if (stable_upd && is_one) begin
            state     <= PRESSED;
            key_code  <= stable_code;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
`ifdef KEY_REPEAT_EN
            rpt_cnt   <= '0;
`endif
          end else if (stable_upd && is_multi) begin
            state     <= BLOCKED;
            multi_key <= 1'b1;
          end
        end
        PRESSED: begin
          if (stable_upd && (is_none || is_multi || stable_code != key_code)) begin
            state       <= is_none ? IDLE : BLOCKED;
            key_release <= 1'b1;
            key_held    <= 1'b0;
            multi_key   <= is_multi;
          end
`ifdef KEY_REPEAT_EN
          else if (frame_tick && !stable_upd) begin
            if (rpt_cnt == RPT_W'(REPEAT_FRAMES - 1)) begin
              key_valid <= 1'b1;
              rpt_cnt   <= '0;
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
          end
`endif
        end
        BLOCKED: begin
          if (stable_upd) begin
            multi_key <= is_multi;
            if (is_none) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Time-multiplexed 4x4 matrix keypad reader; the input-side counterpart of the multiplexed 7-segment display driver.
- Strobes one column at a time, active-low, and samples the four row lines. Debounces complete scan frames and reports single key presses as a one-cycle event with a 4-bit key code.
- Feeds the toy-dog control logic (mode/speed selection) in the same clock domain as the display.

Parameters:
- SCAN_DIV, 50000, clk cycles per column slot (column dwell time); minimum 4.
- DEBOUNCE_FRAMES, 4, consecutive identical full-scan frames required before a frame is accepted as stable; range 1..15.
- REPEAT_FRAMES, 125, stable frames between auto-repeat events (used only with KEY_REPEAT_EN).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-high reset.
- col_n, output, 4, column strobes, active-low, exactly one low at a time.
- row_n, input, 4, row returns, active-low (externally pulled up), asynchronous to clk.
- key_code, output, 4, code of last accepted key = row*4 + col, held until next event.
- key_valid, output, 1, one-cycle pulse: new key press accepted (or repeat event).
- key_release, output, 1, one-cycle pulse: held key released.
- key_held, output, 1, high while a single accepted key is stably pressed.
- multi_key, output, 1, high while the stable frame has 2 or more keys pressed.

Behaviour:
- Reset values:
  - col_n = 4'b1110 (column 0 active); key_code = 0; key_valid = key_release = key_held = multi_key = 0.
  - All counters = 0; FSM = IDLE.
- row_n passes through a 2-flop synchronizer before use.
- Slot counter counts 0..SCAN_DIV-1. The synchronized rows are sampled into frame bits [col*4 +: 4] (inverted, so 1 = pressed) in the cycle where slot = SCAN_DIV-2. This gives the strobe a settling time.
- At slot = SCAN_DIV-1 the column advances 0→1→2→3→0 and the slot counter wraps to 0.
- A full frame completes when column 3's slot ends.
- Debounce:
  - Each completed frame is compared with the previous completed frame.
  - If equal, the match counter increments, saturating at DEBOUNCE_FRAMES. Otherwise the match counter resets to 1.
  - When the match counter reaches DEBOUNCE_FRAMES, the frame becomes the stable frame. It is latched once per distinct frame.
- Classification of the stable frame:
  - NONE = zero bits set.
  - ONE(k) = exactly one bit k set.
  - MULTI = two or more bits set.
- FSM, evaluated one cycle after each stable-frame update:
  - IDLE:
    - ONE(k) → PRESSED; key_code = k; key_valid pulses 1 cycle; key_held = 1.
    - MULTI → BLOCKED; multi_key = 1.
    - NONE → stay.
  - PRESSED:
    - NONE → IDLE; key_release pulses; key_held = 0.
    - MULTI → BLOCKED; key_release pulses; key_held = 0; multi_key = 1.
    - ONE(j), j≠k (key changed without passing through NONE) → BLOCKED; key_release pulses; key_held = 0.
    - ONE(k) → stay.
  - BLOCKED:
    - NONE → IDLE; multi_key = 0.
    - Every other frame → stay. No key_valid is issued until a NONE frame is seen.
- key_valid and key_release are never asserted in the same cycle.
- key_code changes only in the cycle key_valid is asserted.
- Reset mid-scan aborts the frame immediately: no pulses are emitted, and the state returns to the reset values.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In PRESSED, a repeat counter counts completed frames in which the stable frame is still ONE(k).
  - When it reaches REPEAT_FRAMES, key_valid pulses again with the same key_code and the counter clears.
  - The counter clears on entering PRESSED.
- Not defined: the repeat counter logic is absent and key_valid fires exactly once per press.

Test Plan:
- Reset behaviour: assert reset mid-slot → col_n = 4'b1110 and all outputs 0 in the same cycle; after release, col_n rotates 1110→1101→1011→0111 every SCAN_DIV cycles (use SCAN_DIV = 8).
- Single press: SCAN_DIV = 8, DEBOUNCE_FRAMES = 3; hold row 2 low only while col 1 is strobed (key 9) → exactly one key_valid with key_code = 9, after 3 matching frames plus 1 cycle; key_held = 1. Then release → one key_release pulse; key_held = 0.
- Bounce rejection: toggle the row 0/col 0 contact every frame for 10 frames → no key_valid. Then hold it steady → a single key_valid with key_code = 0.
- Two keys: press keys 3 and 12 together → multi_key = 1 and no key_valid. Release key 12 only → still no key_valid. Release all → multi_key = 0; FSM back in IDLE.
- Key change without release: press key 5 (key_valid), then switch directly to key 6 → key_release pulse and no key_valid for 6 until all keys are released and key 6 is pressed again.
- KEY_REPEAT_EN defined, REPEAT_FRAMES = 4: hold key 15 for 14 frames after acceptance → key_valid at acceptance plus 3 repeats, all with key_code = 15. With the macro undefined, exactly 1 pulse.
